// File: rtl/io_display_driver.sv
// Iterative double-dabble driver for six active-low seven-segment digits.
// Optional macro DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits above hex0.
module io_display_driver (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] display_in,
  input  logic        update,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        ovf
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] UPPER_RESET = SEG_BLANK;
`else
  localparam logic [6:0] UPPER_RESET = SEG_ZERO;
`endif

  logic [1:0]  state_reg;
  logic [19:0] bin_reg;
  logic [23:0] bcd_reg;
  logic [4:0]  cnt_reg;
  logic        range_err_reg;
  logic        pend_reg;
  logic [31:0] pend_val_reg;
  logic        busy_reg;
  logic        ovf_reg;
  logic [6:0]  hex_reg [6];

  logic [23:0] bcd_adj;
  logic [3:0]  digit [6];
  logic [6:0]  commit_seg [6];
  logic [31:0] start_val;
  logic        start_err;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // A fresh strobe on the start edge supersedes any older pending value.
  assign start_val = update ? display_in : pend_val_reg;
  assign start_err = (|start_val[31:20]) || (start_val[19:0] > 20'd999999);

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      assign digit[gi] = bcd_reg[4*gi +: 4];
      assign bcd_adj[4*gi +: 4] = (digit[gi] >= 4'd5) ? digit[gi] + 4'd3 : digit[gi];
    end
  endgenerate

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  // lead_zero[i] is set when digit i and every digit above it are zero.
  logic [5:1] lead_zero;
  generate
    for (gi = 1; gi < 6; gi++) begin : g_blank
      if (gi == 5) begin : g_top
        assign lead_zero[gi] = (digit[gi] == 4'd0);
      end else begin : g_low
        assign lead_zero[gi] = lead_zero[gi+1] && (digit[gi] == 4'd0);
      end
      assign commit_seg[gi] = range_err_reg  ? SEG_DASH  :
                              lead_zero[gi]  ? SEG_BLANK : seg7(digit[gi]);
    end
  endgenerate
  assign commit_seg[0] = range_err_reg ? SEG_DASH : seg7(digit[0]);
`else
  generate
    for (gi = 0; gi < 6; gi++) begin : g_show
      assign commit_seg[gi] = range_err_reg ? SEG_DASH : seg7(digit[gi]);
    end
  endgenerate
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      bin_reg       <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      range_err_reg <= 1'b0;
      pend_reg      <= 1'b0;
      pend_val_reg  <= '0;
      busy_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      hex_reg[0]    <= SEG_ZERO;
      for (int i = 1; i < 6; i++) hex_reg[i] <= UPPER_RESET;
    end else begin
      case (state_reg)
        IDLE: begin
          if (update) begin
            bin_reg       <= start_val[19:0];
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            range_err_reg <= start_err;
            busy_reg      <= 1'b1;
            state_reg     <= CONV;
          end
        end
        CONV: begin
          bcd_reg <= {bcd_adj[22:0], bin_reg[19]};
          bin_reg <= {bin_reg[18:0], 1'b0};
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd19) state_reg <= COMMIT;
          if (update) begin
            pend_reg     <= 1'b1;
            pend_val_reg <= display_in;
          end
        end
        COMMIT: begin
          for (int i = 0; i < 6; i++) hex_reg[i] <= commit_seg[i];
          ovf_reg <= range_err_reg;
          if (update || pend_reg) begin
            bin_reg       <= start_val[19:0];
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            range_err_reg <= start_err;
            pend_reg      <= 1'b0;
            state_reg     <= CONV;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign hex0 = hex_reg[0];
  assign hex1 = hex_reg[1];
  assign hex2 = hex_reg[2];
  assign hex3 = hex_reg[3];
  assign hex4 = hex_reg[4];
  assign hex5 = hex_reg[5];
  assign busy = busy_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_io_display_driver.sv
// Directed bench for io_display_driver: vector table plus pending, reset and back-to-back sequences.
module tb_io_display_driver;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] display_in = '0;
  logic        update = 1'b0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy, ovf;

  io_display_driver dut (
    .clock(clock), .resetn(resetn), .display_in(display_in), .update(update),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy), .ovf(ovf)
  );

  always #5 clock = ~clock;

  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000, DASH = 7'b0111111;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'b1111111;
`else
  localparam logic [6:0] LZ = 7'b1000000;
`endif
  localparam logic [41:0] RESET_HEX = {LZ, LZ, LZ, LZ, LZ, D0};
  localparam logic [41:0] ALL_DASH  = {DASH, DASH, DASH, DASH, DASH, DASH};

  typedef struct {
    logic [31:0] val;
    logic [41:0] exp_hex;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [12];
  int total = 0;
  int bad = 0;
  logic [41:0] prev_hex;
  logic        prev_ovf;

  function automatic logic [41:0] cur_hex();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [31:0] v);
    display_in = v;
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'd123456,     {D1, D2, D3, D4, D5, D6}, 1'b0};
    vecs[1]  = '{32'd42,         {LZ, LZ, LZ, LZ, D4, D2}, 1'b0};
    vecs[2]  = '{32'd1000000,    ALL_DASH,                 1'b1};
    vecs[3]  = '{32'd7,          {LZ, LZ, LZ, LZ, LZ, D7}, 1'b0};
    vecs[4]  = '{32'h0010_0000,  ALL_DASH,                 1'b1};
    vecs[5]  = '{32'd7,          {LZ, LZ, LZ, LZ, LZ, D7}, 1'b0};
    vecs[6]  = '{32'd999999,     {D9, D9, D9, D9, D9, D9}, 1'b0};
    vecs[7]  = '{32'd0,          {LZ, LZ, LZ, LZ, LZ, D0}, 1'b0};
    vecs[8]  = '{32'd100005,     {D1, D0, D0, D0, D0, D5}, 1'b0};
    vecs[9]  = '{32'hFFF0_0001,  ALL_DASH,                 1'b1};
    vecs[10] = '{32'h000F_FFFF,  ALL_DASH,                 1'b1};
    vecs[11] = '{32'd50,         {LZ, LZ, LZ, LZ, D5, D0}, 1'b0};

    @(negedge clock);
    resetn = 1'b0;
    steps(2);
    resetn = 1'b1;
    chk("reset_hex", cur_hex(), RESET_HEX);
    chk("reset_busy", {41'd0, busy}, 42'd0);
    chk("reset_ovf", {41'd0, ovf}, 42'd0);
    prev_hex = RESET_HEX;
    prev_ovf = 1'b0;

    for (int i = 0; i < 12; i++) begin
      pulse(vecs[i].val);
      chk("busy_after_sample", {41'd0, busy}, 42'd1);
      steps(20);
      chk("busy_edge20", {41'd0, busy}, 42'd1);
      chk("hold_hex_edge20", cur_hex(), prev_hex);
      chk("hold_ovf_edge20", {41'd0, ovf}, {41'd0, prev_ovf});
      step();
      chk("commit_hex", cur_hex(), vecs[i].exp_hex);
      chk("commit_ovf", {41'd0, ovf}, {41'd0, vecs[i].exp_ovf});
      chk("commit_busy", {41'd0, busy}, 42'd0);
      $display("vec %0d val=%h hex=%h ovf=%b busy=%b", i, vecs[i].val, cur_hex(), ovf, busy);
      prev_hex = vecs[i].exp_hex;
      prev_ovf = vecs[i].exp_ovf;
      step();
    end

    // Updates during conversion: last one wins, no busy gap.
    pulse(32'd111111);
    steps(4);
    pulse(32'd222);
    steps(4);
    pulse(32'd999999);
    steps(10);
    chk("pend_hold_edge20", cur_hex(), prev_hex);
    step();
    chk("pend_first_hex", cur_hex(), {D1, D1, D1, D1, D1, D1});
    chk("pend_first_busy", {41'd0, busy}, 42'd1);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("pend_busy_gap", {41'd0, busy}, 42'd1);
    end
    chk("pend_hold_edge41", cur_hex(), {D1, D1, D1, D1, D1, D1});
    step();
    chk("pend_second_hex", cur_hex(), {D9, D9, D9, D9, D9, D9});
    chk("pend_second_busy", {41'd0, busy}, 42'd0);
    steps(3);
    chk("pend_cleared_busy", {41'd0, busy}, 42'd0);
    $display("seq pending hex=%h busy=%b", cur_hex(), busy);

    // Put ovf high first so reset has something to clear.
    pulse(32'd2000000);
    steps(21);
    chk("pre_reset_ovf", {41'd0, ovf}, 42'd1);
    pulse(32'd555555);
    steps(9);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("abort_hex", cur_hex(), RESET_HEX);
    chk("abort_busy", {41'd0, busy}, 42'd0);
    chk("abort_ovf", {41'd0, ovf}, 42'd0);
    steps(11);
    chk("abort_hex_edge21", cur_hex(), RESET_HEX);
    chk("abort_busy_edge21", {41'd0, busy}, 42'd0);
    steps(4);
    chk("abort_hex_late", cur_hex(), RESET_HEX);
    $display("seq reset hex=%h busy=%b ovf=%b", cur_hex(), busy, ovf);

    // Strobe on the commit edge starts the next conversion immediately.
    pulse(32'd314159);
    steps(20);
    pulse(32'd271828);
    chk("b2b_first_hex", cur_hex(), {D3, D1, D4, D1, D5, D9});
    chk("b2b_first_busy", {41'd0, busy}, 42'd1);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("b2b_busy_gap", {41'd0, busy}, 42'd1);
    end
    chk("b2b_hold_edge41", cur_hex(), {D3, D1, D4, D1, D5, D9});
    step();
    chk("b2b_second_hex", cur_hex(), {D2, D7, D1, D8, D2, D8});
    chk("b2b_second_busy", {41'd0, busy}, 42'd0);
    steps(25);
    chk("b2b_idle_busy", {41'd0, busy}, 42'd0);
    chk("b2b_idle_hex", cur_hex(), {D2, D7, D1, D8, D2, D8});
    $display("seq b2b hex=%h busy=%b", cur_hex(), busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_display_driver.md
IO_DISPLAY_DRIVER -- requirements
Module: io_display_driver

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port resetn, input, 1 bit, a synchronous active-low reset sampled on the rising edge of clock.
REQ-003 The block SHALL have the port display_in, input, 32 bits, the word written by the CPU to the output device at 0x8000_000C.
REQ-004 The block SHALL have the port update, input, 1 bit, a one-cycle strobe that is high in the cycle display_in carries a new value (we & addr==0x8000_000C).
REQ-005 The block SHALL have the ports hex0..hex5, output, 7 bits each, active-low seven-segment digits with bit order {g,f,e,d,c,b,a}; hex0 is the least significant digit.
REQ-006 The block SHALL have the port busy, output, 1 bit, high while a conversion is in progress.
REQ-007 The block SHALL have the port ovf, output, 1 bit, high while the displayed value is out of range.

Function
REQ-008 The block SHALL convert display_in to six BCD digits with an iterative shift-and-add-3 (double-dabble) process over bits [19:0], one bit per clock.
REQ-009 The FSM SHALL have the states IDLE, CONV and COMMIT; IDLE goes to CONV on update; CONV goes to COMMIT after exactly 20 shift cycles; COMMIT goes to IDLE, or to CONV if a value is pending.
REQ-010 On the edge that samples update in IDLE, the block SHALL capture display_in and assert busy.
REQ-011 The hex and ovf outputs SHALL change only on the COMMIT edge, which is the 21st rising edge after the sampling edge; busy SHALL deassert on that same edge unless a value is pending.
REQ-012 Any display_in with bits [31:20] nonzero, or with a [19:0] value greater than 999999, SHALL be treated as out of range.
REQ-013 For an out-of-range value, COMMIT SHALL drive all six digits to dash (7'b0111111) and set ovf=1; for an in-range value, COMMIT SHALL clear ovf.
REQ-014 The segment encoding SHALL be the standard DE-series active-low encoding.
REQ-015 Segment values include: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 An update sampled in CONV or COMMIT SHALL be stored in a pending register and SHALL NOT disturb the conversion in progress.
REQ-017 Multiple updates during one conversion SHALL be resolved last-wins.
REQ-018 A pending value SHALL start conversion on the COMMIT edge, keeping busy high continuously, and the pending flag SHALL clear.
REQ-019 Latency is uniform: out-of-range values SHALL take the same 21 cycles as in-range values.

Reset
REQ-020 With resetn=0 at a rising edge, the FSM SHALL go to IDLE, and busy=0, ovf=0, and the pending flag and shift register SHALL clear.
REQ-021 On reset, hex0 SHALL be set to 1000000 and hex1..hex5 SHALL be set per REQ-023.
REQ-022 Reset during CONV or COMMIT SHALL abort the conversion; no partial result SHALL reach the outputs and any pending value SHALL be lost.

Configuration
REQ-023 The macro DISPLAY_LEADING_ZERO_BLANK_EN SHALL select leading-zero handling.
REQ-024 With the macro defined, COMMIT SHALL blank (7'b1111111) every zero digit above the most significant nonzero digit, hex0 SHALL always be shown, and reset values of hex1..hex5 SHALL be 1111111.
REQ-025 Without the macro, all six digits SHALL always be shown and reset values of hex1..hex5 SHALL be 1000000.
REQ-026 The ovf dash display SHALL be unaffected by the macro.

Verification
REQ-027 The bench SHALL check: update with 32'd123456 -> busy for 21 cycles, then hex5..hex0 show 1,2,3,4,5,6 and ovf=0.
REQ-028 The bench SHALL check: update with 32'd42 -> with the macro, hex5..hex2 are 1111111 and hex1/hex0 show 4/2; without it, hex5..hex2 are 1000000.
REQ-029 The bench SHALL check: update with 32'd1000000, and separately with 32'h0010_0000 -> all digits are 0111111 and ovf=1; a following update with 32'd7 clears ovf.
REQ-030 The bench SHALL check: update with 32'd111111, then updates with 32'd222 at cycle 5 and 32'd999999 at cycle 10 -> first commit shows 111111 at cycle 21, busy stays high, and the second commit shows 999999 at cycle 42 (222 is never displayed).
REQ-031 The bench SHALL check: update with 32'd555555, then resetn=0 at cycle 10 for one cycle -> outputs hold reset values, busy=0, and nothing changes at cycle 21.
REQ-032 The bench SHALL check: update asserted on the COMMIT edge -> the new value is committed 21 cycles later with no busy gap.
